// File: rtl/rmt_pkg.sv
// Shared definitions for the RMT action stage: opcodes, action-word field
// positions and a saturating counter helper.
package rmt_pkg;

  typedef enum logic [1:0] {
    OP_FORWARD   = 2'b00,
    OP_DROP      = 2'b01,
    OP_SET_FIELD = 2'b10,
    OP_RESERVED  = 2'b11
  } op_e;

  localparam int ACT_OP_LSB   = 0;
  localparam int ACT_OP_W     = 2;
  localparam int ACT_OFF_LSB  = 8;
  localparam int ACT_PORT_LSB = 16;
  localparam int ACT_VAL_LSB  = 32;

  // Statistics stick at all-ones instead of wrapping back to zero.
  function automatic logic [31:0] sat_inc(input logic [31:0] cnt);
    return (cnt == 32'hFFFF_FFFF) ? cnt : cnt + 32'd1;
  endfunction

endpackage

// File: rtl/rmt_action_fifo.sv
// Output buffer for the action engine: pointer-based FIFO whose extra pointer
// bit separates full from empty. The caller never pushes into a full FIFO
// unless it pops in the same cycle, and never pops an empty one.
module rmt_action_fifo #(
  parameter int WIDTH = 520,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = 1;

  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q[AW-1:0]] <= wdata;
  end

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                 (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  // Head reads as zero when empty so the egress bus is clean in and after reset.
  assign rdata = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];

endmodule

// File: rtl/rmt_action_engine.sv
// RMT action engine: applies the hit/default action to each PHV through a
// two-stage pipeline and buffers forwarded packets for the egress port.
module rmt_action_engine
  import rmt_pkg::*;
#(
  parameter int PHV_WIDTH  = 512,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  input  logic [PHV_WIDTH-1:0] in_phv,
  input  logic                 in_match_found,
  input  logic [7:0]           in_match_addr,
  input  logic [63:0]          in_action,
  input  logic [63:0]          cfg_default_action,
  // Egress: out_valid is high while an entry is buffered; a pop happens on
  // every edge with out_valid && out_ready; while stalled the head holds.
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [PHV_WIDTH-1:0] out_phv,
  output logic [7:0]           out_port,
  output logic [31:0]          fwd_count,
  output logic [31:0]          drop_count,
  output logic [31:0]          ovf_count,
  output logic [31:0]          err_count
);

  localparam int MAX_OFF  = PHV_WIDTH / 8 - 4;
  localparam int LAST_OFF = (MAX_OFF > 255) ? 255 : MAX_OFF;
  localparam logic [8:0] OFF_LIMIT = 9'(LAST_OFF);

  typedef struct packed {
    logic [PHV_WIDTH-1:0] phv;
    op_e                  op;
    logic [7:0]           off;
    logic [7:0]           port;
    logic [31:0]          val;
  } s1_t;

  typedef struct packed {
    logic [PHV_WIDTH-1:0] phv;
    logic [7:0]           port;
  } s2_t;

  logic [63:0]          act_eff;
  logic                 s1_valid_q, s1_valid_d;
  s1_t                  s1_q, s1_d;
  logic                 s2_valid_q, s2_valid_d;
  s2_t                  s2_q, s2_d;
  logic [PHV_WIDTH-1:0] phv_mod;
  logic                 do_fwd, is_drop, is_err;
  logic                 fifo_full, fifo_empty, fifo_push, fifo_pop, fifo_ovf;
  logic [PHV_WIDTH+7:0] fifo_head;
  logic [31:0]          fwd_count_q, fwd_count_d, drop_count_q, drop_count_d;
  logic [31:0]          ovf_count_q, ovf_count_d, err_count_q, err_count_d;
  logic                 unused_bits;

  // Stage 1: select and decode the effective action.
  always_comb begin
    act_eff     = in_match_found ? in_action : cfg_default_action;
    s1_valid_d  = in_valid;
    s1_d.phv    = in_phv;
    s1_d.op     = op_e'(act_eff[ACT_OP_LSB +: ACT_OP_W]);
    s1_d.off    = act_eff[ACT_OFF_LSB +: 8];
    s1_d.port   = act_eff[ACT_PORT_LSB +: 8];
    s1_d.val    = act_eff[ACT_VAL_LSB +: 32];
  end

  assign unused_bits = ^{in_match_addr, act_eff[31:24], act_eff[7:2]};

  // Stage 2: execute; an out-of-range SET_FIELD still forwards, unmodified.
  always_comb begin
    phv_mod = s1_q.phv;
    do_fwd  = 1'b0;
    is_drop = 1'b0;
    is_err  = 1'b0;
    case (s1_q.op)
      OP_FORWARD: do_fwd = 1'b1;
      OP_DROP:    is_drop = 1'b1;
      OP_SET_FIELD: begin
        do_fwd = 1'b1;
        if ({1'b0, s1_q.off} > OFF_LIMIT) begin
          is_err = 1'b1;
        end else begin
          for (int b = 0; b <= LAST_OFF; b++) begin
            if (s1_q.off == 8'(b)) phv_mod[b*8 +: 32] = s1_q.val;
          end
        end
      end
      default: is_err = 1'b1;
    endcase
    s2_valid_d = s1_valid_q && do_fwd;
    s2_d.phv   = phv_mod;
    s2_d.port  = s1_q.port;
  end

  // FIFO write stage: a push while full is only legal alongside a pop.
  always_comb begin
    fifo_pop     = out_valid && out_ready;
    fifo_push    = s2_valid_q && (!fifo_full || fifo_pop);
    fifo_ovf     = s2_valid_q && fifo_full && !fifo_pop;
    fwd_count_d  = fifo_push ? sat_inc(fwd_count_q) : fwd_count_q;
    ovf_count_d  = fifo_ovf ? sat_inc(ovf_count_q) : ovf_count_q;
    drop_count_d = (s1_valid_q && is_drop) ? sat_inc(drop_count_q) : drop_count_q;
    err_count_d  = (s1_valid_q && is_err) ? sat_inc(err_count_q) : err_count_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q   <= 1'b0;
      s1_q         <= '0;
      s2_valid_q   <= 1'b0;
      s2_q         <= '0;
      fwd_count_q  <= '0;
      drop_count_q <= '0;
      ovf_count_q  <= '0;
      err_count_q  <= '0;
    end else begin
      s1_valid_q   <= s1_valid_d;
      s1_q         <= s1_d;
      s2_valid_q   <= s2_valid_d;
      s2_q         <= s2_d;
      fwd_count_q  <= fwd_count_d;
      drop_count_q <= drop_count_d;
      ovf_count_q  <= ovf_count_d;
      err_count_q  <= err_count_d;
    end
  end

  rmt_action_fifo #(
    .WIDTH(PHV_WIDTH + 8),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (fifo_push),
    .wdata ({s2_q.port, s2_q.phv}),
    .pop   (fifo_pop),
    .rdata (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign out_valid            = !fifo_empty;
  assign {out_port, out_phv}  = fifo_head;
  assign fwd_count            = fwd_count_q;
  assign drop_count           = drop_count_q;
  assign ovf_count            = ovf_count_q;
  assign err_count            = err_count_q;

endmodule

// File: tb/tb_rmt_action_engine.sv
// Bench for rmt_action_engine: directed vector table, hand-written multi-cycle
// sequences and a randomized run, all scored against a queue-based model.
module tb_rmt_action_engine;

  localparam int PW    = 512;
  localparam int DEPTH = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          in_valid = 1'b0;
  logic [PW-1:0] in_phv = '0;
  logic          in_match_found = 1'b0;
  logic [7:0]    in_match_addr = '0;
  logic [63:0]   in_action = '0;
  logic [63:0]   cfg_default_action = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [PW-1:0] out_phv;
  logic [7:0]    out_port;
  logic [31:0]   fwd_count, drop_count, ovf_count, err_count;

  int checks = 0;
  int errs   = 0;

  rmt_action_engine #(.PHV_WIDTH(PW), .FIFO_DEPTH(DEPTH)) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .in_valid           (in_valid),
    .in_phv             (in_phv),
    .in_match_found     (in_match_found),
    .in_match_addr      (in_match_addr),
    .in_action          (in_action),
    .cfg_default_action (cfg_default_action),
    .out_valid          (out_valid),
    .out_ready          (out_ready),
    .out_phv            (out_phv),
    .out_port           (out_port),
    .fwd_count          (fwd_count),
    .drop_count         (drop_count),
    .ovf_count          (ovf_count),
    .err_count          (err_count)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  typedef struct packed {
    logic          valid;
    logic          fwd;
    logic          drop;
    logic          err;
    logic [PW+7:0] ent;
  } res_t;

  logic [PW+7:0] exp_q[$];
  res_t          st1, st2;
  logic [31:0]   m_fwd, m_drop, m_ovf, m_err;

  function automatic logic [31:0] bump(input logic [31:0] c);
    return (c == 32'hFFFF_FFFF) ? c : c + 32'd1;
  endfunction

  // Result of one packet, straight from the action rules.
  function automatic res_t eval_action(input logic found, input logic [63:0] act,
                                       input logic [63:0] dflt, input logic [PW-1:0] phv);
    res_t          r;
    logic [63:0]   a;
    logic [PW-1:0] p;
    int            op, off;
    a = found ? act : dflt;
    p = phv;
    op = int'(a[1:0]);
    off = int'(a[15:8]);
    r = '0;
    r.valid = 1'b1;
    if (op == 0) r.fwd = 1'b1;
    else if (op == 1) r.drop = 1'b1;
    else if (op == 2) begin
      r.fwd = 1'b1;
      if (off * 8 + 32 <= PW) p[off*8 +: 32] = a[63:32];
      else r.err = 1'b1;
    end else r.err = 1'b1;
    r.ent = {a[23:16], p};
    return r;
  endfunction

  function automatic void model_clear();
    exp_q.delete();
    st1 = '0;
    st2 = '0;
    m_fwd = '0; m_drop = '0; m_ovf = '0; m_err = '0;
  endfunction

  // Advance the model across one rising edge using the currently driven inputs.
  function automatic void model_edge();
    if (exp_q.size() > 0 && out_ready) void'(exp_q.pop_front());
    if (st2.valid && st2.fwd) begin
      if (exp_q.size() < DEPTH) begin
        exp_q.push_back(st2.ent);
        m_fwd = bump(m_fwd);
      end else m_ovf = bump(m_ovf);
    end
    if (st1.valid && st1.drop) m_drop = bump(m_drop);
    if (st1.valid && st1.err)  m_err  = bump(m_err);
    st2 = st1;
    st1 = in_valid ? eval_action(in_match_found, in_action, cfg_default_action, in_phv) : '0;
  endfunction

  // ---------------- scoreboard helpers ----------------
  task automatic chk32(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic chk_ent(input string name, input logic [PW+7:0] got, input logic [PW+7:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic check_outputs();
    chk32("out_valid", 32'(out_valid), 32'(exp_q.size() != 0));
    if (exp_q.size() != 0) chk_ent("out_head", {out_port, out_phv}, exp_q[0]);
    chk32("fwd_count", fwd_count, m_fwd);
    chk32("drop_count", drop_count, m_drop);
    chk32("ovf_count", ovf_count, m_ovf);
    chk32("err_count", err_count, m_err);
  endtask

  // ---------------- driver tasks ----------------
  function automatic logic [PW-1:0] rand_phv();
    logic [PW-1:0] p;
    for (int i = 0; i < PW / 32; i++) p[i*32 +: 32] = $urandom;
    return p;
  endfunction

  task automatic drive_pkt(input logic found, input logic [63:0] act,
                           input logic [63:0] dflt, input logic [PW-1:0] phv);
    in_valid           = 1'b1;
    in_match_found     = found;
    in_action          = act;
    cfg_default_action = dflt;
    in_phv             = phv;
    in_match_addr      = 8'($urandom_range(0, 255));
  endtask

  task automatic drive_idle();
    in_valid       = 1'b0;
    in_match_found = 1'b0;
    in_phv         = rand_phv();
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
    check_outputs();
  endtask

  task automatic do_reset();
    drive_idle();
    rst_n = 1'b0;
    #1;
    model_clear();
    chk32("rst_out_valid", 32'(out_valid), 32'd0);
    chk_ent("rst_out_bus", {out_port, out_phv}, '0);
    chk32("rst_fwd", fwd_count, 32'd0);
    chk32("rst_drop", drop_count, 32'd0);
    chk32("rst_ovf", ovf_count, 32'd0);
    chk32("rst_err", err_count, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    string       name;
    logic        found;
    logic [63:0] act;
    logic [63:0] dflt;
    logic        exp_out;
    logic [7:0]  exp_port;
    int          field_off;
    logic [31:0] field_val;
    logic        exp_drop;
    logic        exp_err;
  } vec_t;

  vec_t tv[10];

  initial begin
    #200_000;
    errs++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [PW-1:0] phv;
    logic [PW+7:0] exp_ent;
    logic [PW-1:0] sent[10];
    logic [31:0]   t_fwd, t_drop, t_err;
    int            cnt, bias, op, off;

    tv[0] = '{"fwd_hit",   1'b1, 64'h0000_0000_0003_0000, 64'h0000_0000_0000_0001, 1'b1, 8'h03, -1, 32'h0, 1'b0, 1'b0};
    tv[1] = '{"miss_drop", 1'b0, 64'h0000_0000_0007_0000, 64'h0000_0000_0000_0001, 1'b0, 8'h00, -1, 32'h0, 1'b1, 1'b0};
    tv[2] = '{"set_field", 1'b1, 64'hDEAD_BEEF_0005_1002, 64'h0000_0000_0000_0001, 1'b1, 8'h05, 16, 32'hDEAD_BEEF, 1'b0, 1'b0};
    tv[3] = '{"set_oob61", 1'b1, 64'hDEAD_BEEF_0005_3D02, 64'h0000_0000_0000_0001, 1'b1, 8'h05, -1, 32'h0, 1'b0, 1'b1};
    tv[4] = '{"reserved",  1'b1, 64'h0000_0000_0007_0003, 64'h0000_0000_0000_0000, 1'b0, 8'h00, -1, 32'h0, 1'b0, 1'b1};
    tv[5] = '{"set_last",  1'b1, 64'h1234_5678_0009_3C02, 64'h0000_0000_0000_0001, 1'b1, 8'h09, 60, 32'h1234_5678, 1'b0, 1'b0};
    tv[6] = '{"set_first", 1'b1, 64'hA5A5_5A5A_0011_0002, 64'h0000_0000_0000_0001, 1'b1, 8'h11, 0, 32'hA5A5_5A5A, 1'b0, 1'b0};
    tv[7] = '{"miss_fwd",  1'b0, 64'h0000_0000_0000_0001, 64'h0000_0000_0022_0000, 1'b1, 8'h22, -1, 32'h0, 1'b0, 1'b0};
    tv[8] = '{"set_oobFF", 1'b1, 64'h0BAD_F00D_0006_FF02, 64'h0000_0000_0000_0001, 1'b1, 8'h06, -1, 32'h0, 1'b0, 1'b1};
    tv[9] = '{"hit_fwd44", 1'b1, 64'h0000_0000_0044_0000, 64'h0000_0000_0000_0001, 1'b1, 8'h44, -1, 32'h0, 1'b0, 1'b0};

    #2;
    do_reset();

    // Single packets, ready always high: latency, data and counter deltas.
    out_ready = 1'b1;
    t_fwd = '0; t_drop = '0; t_err = '0;
    for (int i = 0; i < 10; i++) begin
      phv = rand_phv();
      drive_pkt(tv[i].found, tv[i].act, tv[i].dflt, phv);
      tick();
      drive_idle();
      tick();
      chk32({tv[i].name, "_early"}, 32'(out_valid), 32'd0);
      tick();
      exp_ent = {tv[i].exp_port, phv};
      if (tv[i].field_off >= 0) exp_ent[tv[i].field_off*8 +: 32] = tv[i].field_val;
      chk32({tv[i].name, "_valid"}, 32'(out_valid), 32'(tv[i].exp_out));
      if (tv[i].exp_out) chk_ent({tv[i].name, "_data"}, {out_port, out_phv}, exp_ent);
      tick();
      t_fwd  = t_fwd + 32'(tv[i].exp_out);
      t_drop = t_drop + 32'(tv[i].exp_drop);
      t_err  = t_err + 32'(tv[i].exp_err);
      chk32({tv[i].name, "_fwd_cnt"}, fwd_count, t_fwd);
      chk32({tv[i].name, "_drop_cnt"}, drop_count, t_drop);
      chk32({tv[i].name, "_err_cnt"}, err_count, t_err);
    end

    // Ten forwards into a stalled egress: eight buffered, two overflow, order kept.
    do_reset();
    out_ready = 1'b0;
    for (int k = 0; k < 10; k++) begin
      sent[k] = rand_phv();
      drive_pkt(1'b1, {40'h0, 8'(k), 16'h0000}, 64'h1, sent[k]);
      tick();
    end
    drive_idle();
    repeat (3) tick();
    chk32("stall_ovf", ovf_count, 32'd2);
    chk32("stall_fwd", fwd_count, 32'd8);
    out_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      chk32("drain_valid", 32'(out_valid), 32'd1);
      chk_ent("drain_order", {out_port, out_phv}, {8'(k), sent[k]});
      tick();
    end
    chk32("drain_empty", 32'(out_valid), 32'd0);

    // Full FIFO with a continuous stream and ready high: pop and push together.
    do_reset();
    out_ready = 1'b0;
    for (int k = 0; k < 30; k++) begin
      if (k == 10) out_ready = 1'b1;
      drive_pkt(1'b1, {40'h0, 8'(k), 16'h0000}, 64'h1, rand_phv());
      tick();
    end
    drive_idle();
    cnt = 0;
    for (int i = 0; i < 30 && out_valid; i++) begin
      cnt++;
      tick();
    end
    chk32("stream_drain_cnt", 32'(cnt), 32'd10);
    chk32("stream_ovf", ovf_count, 32'd0);
    chk32("stream_fwd", fwd_count, 32'd30);

    // Reset with three buffered and two in flight: nothing survives.
    do_reset();
    out_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      drive_pkt(1'b1, {40'h0, 8'(k + 1), 16'h0000}, 64'h1, rand_phv());
      tick();
    end
    chk32("pre_rst_valid", 32'(out_valid), 32'd1);
    do_reset();
    out_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      tick();
      chk32("post_rst_quiet", 32'(out_valid), 32'd0);
    end

    // Randomized traffic with varying egress back-pressure.
    bias = 0;
    for (int c = 0; c < 600; c++) begin
      if (c % 50 == 0) bias = $urandom_range(0, 4);
      out_ready = ($urandom_range(1, 4) > bias);
      if ($urandom_range(0, 3) != 0) begin
        op  = $urandom_range(0, 3);
        off = $urandom_range(0, 70);
        drive_pkt(1'($urandom_range(0, 1)),
                  {32'($urandom), 8'h00, 8'($urandom_range(0, 255)), 8'(off), 6'h00, 2'(op)},
                  {32'($urandom), 8'h00, 8'($urandom_range(0, 255)), 8'($urandom_range(0, 70)),
                   6'h00, 2'($urandom_range(0, 3))},
                  rand_phv());
      end else drive_idle();
      tick();
    end
    drive_idle();
    out_ready = 1'b1;
    repeat (12) tick();
    chk32("final_empty", 32'(out_valid), 32'd0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
